// File: rtl/audio_pkg.sv
// audio_pkg: default I2S framing constants and the stereo sample pair type
package audio_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int SLOT_W_DEF   = 32;
  localparam int BCLK_DIV_DEF = 4;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } stereo_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into BCLK/LRCK and marks bit ticks and frame wraps
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  output logic                          bit_tick,
  output logic                          frame_wrap,
  output logic [$clog2(2*SLOT_W)-1:0]   bit_nxt,
  output logic                          aud_bclk,
  output logic                          aud_lrck
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2*SLOT_W);
  localparam logic [DW-1:0] DIV_MID  = DW'(BCLK_DIV/2-1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_W-1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_W);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bclk_q, bclk_d, lrck_q, lrck_d;
  always_comb begin
    bit_tick   = run & (div_cnt_q == DIV_LAST);
    frame_wrap = bit_tick & (bit_cnt_q == BIT_LAST);
    div_cnt_d  = (!run || bit_tick) ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = (!run || frame_wrap) ? '0 : bit_tick ? bit_cnt_q + 1'b1 : bit_cnt_q;
    bclk_d     = !run ? 1'b0 : (div_cnt_q == DIV_MID) ? 1'b1 : bit_tick ? 1'b0 : bclk_q;
    lrck_d     = bit_cnt_d >= SLOT;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
    end
  end
  assign bit_nxt  = bit_cnt_d;
  assign aud_bclk = bclk_q;
  assign aud_lrck = lrck_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers stereo pairs from a valid/ready stream and shifts them out
// MSB-first in I2S format, running only while the audio PLL reports lock.
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              aud_bclk,
  output logic              aud_lrck,
  output logic              aud_dacdat,
  output logic              frame_start,
  output logic              underrun
);
  localparam int BW = $clog2(2*SLOT_W);
  localparam logic [BW-1:0] L_FIRST = BW'(1);
  localparam logic [BW-1:0] L_LAST  = BW'(DATA_W);
  localparam logic [BW-1:0] R_FIRST = BW'(SLOT_W+1);
  localparam logic [BW-1:0] R_LAST  = BW'(SLOT_W+DATA_W);
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;
  logic [1:0]    sync_q, sync_d;
  logic          run, hs, shl, shr, bit_tick, frame_wrap;
  logic [BW-1:0] bit_nxt;
  logic          hold_full_q, hold_full_d, armed_q, armed_d;
  logic          dacdat_q, dacdat_d, frame_start_q, frame_start_d, underrun_q, underrun_d;
  pair_t         hold_q, hold_d, sh_q, sh_d;
  i2s_bclk_gen #(.SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .bit_tick   (bit_tick),
    .frame_wrap (frame_wrap),
    .bit_nxt    (bit_nxt),
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck)
  );
  assign run     = sync_q[1];
  assign s_ready = run & ~hold_full_q;
  assign hs      = s_valid & s_ready;
  // armed_q stays low until the first wrap after lock, so that load never flags underrun
  always_comb begin
    sync_d        = {sync_q[0], pll_locked};
    shl           = bit_tick & (bit_nxt >= L_FIRST) & (bit_nxt <= L_LAST);
    shr           = bit_tick & (bit_nxt >= R_FIRST) & (bit_nxt <= R_LAST);
    hold_full_d   = run & (hs | (hold_full_q & ~frame_wrap));
    hold_d        = !run ? '0 : hs ? {s_left, s_right} : hold_q;
    sh_d          = !run ? '0 : frame_wrap ? (hold_full_q ? hold_q : '0) :
                    {shl ? sh_q.left << 1 : sh_q.left, shr ? sh_q.right << 1 : sh_q.right};
    dacdat_d      = shl ? sh_q.left[DATA_W-1] : shr ? sh_q.right[DATA_W-1] :
                    (bit_tick | ~run) ? 1'b0 : dacdat_q;
    frame_start_d = frame_wrap;
    armed_d       = run & (armed_q | frame_wrap);
    underrun_d    = frame_wrap & armed_q & ~hold_full_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      hold_full_q   <= 1'b0;
      hold_q        <= '0;
      sh_q          <= '0;
      armed_q       <= 1'b0;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      hold_full_q   <= hold_full_d;
      hold_q        <= hold_d;
      sh_q          <= sh_d;
      armed_q       <= armed_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end
  assign aud_dacdat  = dacdat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: frame-timeline reference model plus directed and random I2S checks
module tb_i2s_tx_serializer;
  logic        clk = 1'b0, reset_n = 1'b1, pll_locked = 1'b0, s_valid = 1'b0;
  logic [15:0] s_left = '0, s_right = '0;
  logic        s_ready, aud_bclk, aud_lrck, aud_dacdat, frame_start, underrun;

  i2s_tx_serializer dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_dacdat(aud_dacdat),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] l; logic [15:0] r; logic [63:0] frame; } vec_t;
  vec_t vecs [4];

  int ntest = 0, nfail = 0;
  // model: w = clk edges since run rose (-1 while idle); a frame is 256 clk, a bit 4 clk
  int          w = -1;
  bit          s1_m = 0, run_m = 0, full_m = 0, under_m = 0, last_hs = 0;
  logic [15:0] pend_l = '0, pend_r = '0, cur_l = '0, cur_r = '0;
  logic [63:0] cap = '0;
  logic [63:0] frm [0:255];

  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r);
    bit          hs, run_new, e_dat;
    int          pos, bitn, k;
    logic [15:0] ch;
    s_valid = v;
    s_left  = l;
    s_right = r;
    hs = run_m && v && !full_m;
    @(posedge clk);
    run_new = s1_m;
    s1_m    = pll_locked;
    if (run_m) begin
      w++;
      if (w % 256 == 0) begin
        under_m = (w >= 512) && !full_m;
        cur_l   = full_m ? pend_l : 16'h0;
        cur_r   = full_m ? pend_r : 16'h0;
        full_m  = 0;
      end
      if (hs) begin
        full_m = 1;
        pend_l = l;
        pend_r = r;
      end
    end else begin
      w       = run_new ? 0 : -1;
      full_m  = 0;
      cur_l   = '0;
      cur_r   = '0;
      under_m = 0;
    end
    run_m   = run_new;
    last_hs = hs;
    #1;
    chk("s_ready", s_ready, run_m && !full_m);
    if (w < 0) begin
      chk("idle_outputs", {aud_bclk, aud_lrck, aud_dacdat, frame_start, underrun}, 5'b0);
    end else begin
      pos   = w % 256;
      bitn  = pos / 4;
      k     = bitn % 32;
      ch    = (bitn < 32) ? cur_l : cur_r;
      ch    = ch << (k - 1);
      e_dat = (k >= 1 && k <= 16) ? ch[15] : 1'b0;
      chk("aud_bclk", aud_bclk, (w % 4) >= 2);
      chk("aud_lrck", aud_lrck, bitn >= 32);
      chk("aud_dacdat", aud_dacdat, e_dat);
      chk("frame_start", frame_start, pos == 0 && w >= 256);
      chk("underrun", underrun, pos == 0 && w >= 256 && under_m);
      if (pos == 0 && w >= 256) frm[w/256-1] = cap;
      if (w % 4 == 0) cap[63-bitn] = aud_dacdat;
    end
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      step(0, '0, '0);
      n++;
    end while (!(w >= 0 && w % 256 == p) && n < 1000);
    if (n >= 1000) begin
      ntest++;
      nfail++;
      $display("FAIL wait_pos: frame position %0d not reached in %0d clk (w=%0d)", p, n, w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fs_n, un_n, both_n, low_n, rise_n, fs_t1, fs_t2, fa;
    bit prev_bclk;
    vecs[0] = '{16'hA5F0, 16'h0F0F, 64'h52F80000_07878000};
    vecs[1] = '{16'hFFFF, 16'h0001, 64'h7FFF8000_00008000};
    vecs[2] = '{16'h8000, 16'h7FFF, 64'h40000000_3FFF8000};
    vecs[3] = '{16'h1234, 16'hFEDC, 64'h091A0000_7F6E0000};
    for (int i = 0; i < 256; i++) frm[i] = '0;

    #2 reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("reset_outputs", {aud_bclk, aud_lrck, aud_dacdat, frame_start, underrun, s_ready}, 6'b0);
    end
    reset_n = 1'b1;
    repeat (4) step(0, '0, '0);

    pll_locked = 1'b1;
    n = 0;
    do begin
      step(0, '0, '0);
      n++;
    end while (!s_ready && n < 8);
    ntest++;
    if (!s_ready || n > 3) begin
      nfail++;
      $display("FAIL ready_after_lock: s_ready=%0b after %0d clk, required 1 within 3 clk", s_ready, n);
    end

    wait_pos(10);
    fs_n = 0; low_n = 0; rise_n = 0; fs_t1 = -1; fs_t2 = -1; prev_bclk = aud_bclk;
    for (int i = 0; i < 512; i++) begin
      step(0, '0, '0);
      if (frame_start) begin
        fs_n++;
        if (fs_t1 < 0) fs_t1 = i; else fs_t2 = i;
      end
      if (!aud_lrck) low_n++;
      if (aud_bclk && !prev_bclk) rise_n++;
      prev_bclk = aud_bclk;
    end
    chk("frame_start_count", fs_n, 2);
    chk("frame_start_spacing", fs_t2 - fs_t1, 256);
    chk("lrck_low_clks", low_n, 256);
    chk("bclk_rises", rise_n, 128);

    for (int i = 0; i < 4; i++) begin
      step(1, vecs[i].l, vecs[i].r);
      fa = w / 256;
      wait_pos(10);
      wait_pos(10);
      chk($sformatf("frame_vec%0d", i), frm[fa+1], vecs[i].frame);
    end

    un_n = 0; both_n = 0;
    repeat (256) begin
      step(0, '0, '0);
      if (underrun) un_n++;
      if (underrun && frame_start) both_n++;
    end
    chk("empty_frame_underruns", un_n, 1);
    chk("underrun_with_frame_start", both_n, 1);

    wait_pos(10);
    step(1, 16'hC3A5, 16'h5A3C);
    fa = w / 256;
    n = 0;
    do begin
      step(1, 16'h0123, 16'h4567);
      n++;
    end while (!last_hs && n < 400);
    chk("second_pair_accept_pos", w % 256, 1);
    step(0, '0, '0);
    wait_pos(255);
    wait_pos(255);
    step(1, 16'h89AB, 16'hCDEF);
    chk("ready_after_coincident_load", s_ready, 1'b0);
    wait_pos(10);
    wait_pos(10);
    wait_pos(10);
    chk("b2b_frame_a", frm[fa+1], exp_frame(16'hC3A5, 16'h5A3C));
    chk("b2b_frame_b", frm[fa+2], exp_frame(16'h0123, 16'h4567));
    chk("b2b_frame_gap", frm[fa+3], 64'h0);
    chk("b2b_frame_c", frm[fa+4], exp_frame(16'h89AB, 16'hCDEF));

    wait_pos(10);
    step(1, 16'hDEAD, 16'hBEEF);
    wait_pos(160);
    pll_locked = 1'b0;
    repeat (3) step(0, '0, '0);
    chk("drop_idle_3clk", {aud_bclk, aud_lrck, aud_dacdat, frame_start, underrun, s_ready}, 6'b0);
    repeat (5) step(0, '0, '0);
    pll_locked = 1'b1;
    fs_n = 0; un_n = 0;
    repeat (300) begin
      step(0, '0, '0);
      if (frame_start) fs_n++;
      if (underrun) un_n++;
    end
    chk("relock_frame_starts", fs_n, 1);
    chk("relock_first_underrun", un_n, 0);
    repeat (220) step(0, '0, '0);
    chk("relock_hold_flushed", frm[1], 64'h0);

    for (int i = 0; i < 12000; i++) begin
      if (pll_locked && $urandom_range(0, 4999) == 0) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 9) == 0) pll_locked = 1'b1;
      step($urandom_range(0, 119) == 0, 16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
